// File: rtl/varredura_matriz.sv
`default_nettype none
// ============================================================================
// Module      : varredura_matriz
// Description : 7x5 LED matrix row scanner with a per-frame column buffer and
//               registered outputs. Define VARREDURA_BLANKING_EN to insert one
//               dark APAGA cycle between consecutive rows.
// Revision    : 1.0 - initial release
// ============================================================================
module varredura_matriz #(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [34:0] dados,
  output logic [6:0]  linha,
  output logic [4:0]  coluna,
  output logic        frame_fim
);

`ifdef VARREDURA_BLANKING_EN
  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CARGA  = 2'd1,
    VARRE  = 2'd2,
    APAGA  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CARGA  = 2'd1,
    VARRE  = 2'd2
  } state_t;
`endif

  localparam logic [7:0] PRESC_MAX = 8'(DIV - 1);
  localparam logic [2:0] LAST_ROW  = 3'd6;

  state_t      state_q, state_d;
  logic [2:0]  row_q, row_d;
  logic [7:0]  presc_q, presc_d;
  logic [34:0] buf_q, buf_d;
  logic [6:0]  linha_q, linha_d;
  logic [4:0]  coluna_q, coluna_d;
  logic        fim_q, fim_d;
  logic [2:0]  row_inc;
  logic        tick;

  function automatic logic [4:0] row_bits(input logic [34:0] b, input logic [2:0] r);
    case (r)
      3'd0:    return b[4:0];
      3'd1:    return b[9:5];
      3'd2:    return b[14:10];
      3'd3:    return b[19:15];
      3'd4:    return b[24:20];
      3'd5:    return b[29:25];
      3'd6:    return b[34:30];
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [6:0] row_onehot(input logic [2:0] r);
    return 7'b000_0001 << r;
  endfunction

  assign row_inc = row_q + 3'd1;
  assign tick    = (presc_q == PRESC_MAX);

  // Outputs are computed for the next state so that they leave registers.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    presc_d  = presc_q;
    buf_d    = buf_q;
    linha_d  = 7'd0;
    coluna_d = 5'd0;
    fim_d    = 1'b0;
    case (state_q)
      OCIOSO: begin
        row_d   = 3'd0;
        presc_d = 8'd0;
        if (en) state_d = CARGA;
      end
      CARGA: begin
        buf_d    = dados;
        row_d    = 3'd0;
        presc_d  = 8'd0;
        state_d  = VARRE;
        linha_d  = row_onehot(3'd0);
        coluna_d = dados[4:0];
      end
      VARRE: begin
        if (tick) begin
          presc_d = 8'd0;
          if (row_q == LAST_ROW) begin
            state_d = CARGA;
            row_d   = 3'd0;
            fim_d   = 1'b1;
          end else begin
            row_d = row_inc;
`ifdef VARREDURA_BLANKING_EN
            state_d = APAGA;
`else
            linha_d  = row_onehot(row_inc);
            coluna_d = row_bits(buf_q, row_inc);
`endif
          end
        end else begin
          presc_d  = presc_q + 8'd1;
          linha_d  = row_onehot(row_q);
          coluna_d = row_bits(buf_q, row_q);
        end
      end
`ifdef VARREDURA_BLANKING_EN
      APAGA: begin
        state_d  = VARRE;
        linha_d  = row_onehot(row_q);
        coluna_d = row_bits(buf_q, row_q);
      end
`endif
      default: state_d = OCIOSO;
    endcase
    // Disable wins over a tick or frame end in the same cycle.
    if (!en) begin
      state_d  = OCIOSO;
      row_d    = 3'd0;
      presc_d  = 8'd0;
      linha_d  = 7'd0;
      coluna_d = 5'd0;
      fim_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= OCIOSO;
      row_q    <= 3'd0;
      presc_q  <= 8'd0;
      buf_q    <= 35'd0;
      linha_q  <= 7'd0;
      coluna_q <= 5'd0;
      fim_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      presc_q  <= presc_d;
      buf_q    <= buf_d;
      linha_q  <= linha_d;
      coluna_q <= coluna_d;
      fim_q    <= fim_d;
    end
  end

  assign linha     = linha_q;
  assign coluna    = coluna_q;
  assign frame_fim = fim_q;

endmodule
`default_nettype wire

// File: doc/varredura_matriz.md
VARREDURA_MATRIZ -- requirements
Module: varredura_matriz

Interface
REQ-001 SHALL have parameter DIV, default 4: clock cycles each row is displayed; legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port en, input, 1 bit: scan enable; 1 = scan, 0 = idle and dark.
REQ-005 SHALL have port dados, input, 35 bits: column patterns from the row preset stages; row r occupies dados[5r+4:5r], r = 0..6.
REQ-006 SHALL have port linha, output, 7 bits: one-hot row drive, active-high; bit r = row r.
REQ-007 SHALL have port coluna, output, 5 bits: column drive for the active row, active-high.
REQ-008 SHALL have port frame_fim, output, 1 bit: one-cycle pulse at the end of each complete frame.

Function
REQ-009 SHALL implement states OCIOSO, CARGA, VARRE and, when configured, APAGA.
REQ-010 SHALL register every output; no combinational path from any input to any output.
REQ-011 SHALL, in OCIOSO with en=1, move to CARGA; with en=0, stay in OCIOSO.
REQ-012 SHALL, in CARGA, capture dados into a 35-bit frame buffer, set row=0, clear the prescaler and move to VARRE.
REQ-013 SHALL hold linha=0 and coluna=0 in OCIOSO, CARGA and APAGA.
REQ-014 SHALL, in VARRE, drive linha=1<<row and coluna=buffer[5row+4:5row].
REQ-015 SHALL, in VARRE, increment the prescaler each cycle over 0..DIV-1; tick is prescaler==DIV-1, after which the prescaler wraps to 0.
REQ-016 SHALL, on tick with row<6, advance to row+1, via APAGA when configured.
REQ-017 SHALL, on tick with row==6, assert frame_fim for exactly one cycle, coinciding with the cycle spent in CARGA, and move to CARGA to reload the buffer.
REQ-018 SHALL show the first row in the cycle after CARGA: en rises before edge k -> CARGA after edge k -> row 0 visible after edge k+1.
REQ-019 SHALL ignore dados changes outside CARGA; the frame buffer is stable for a whole frame (no tearing).
REQ-020 SHALL, when en=0 in any state other than OCIOSO, go to OCIOSO on the next edge and clear row and prescaler; re-enable restarts at CARGA and row 0.
REQ-021 SHALL give en=0 priority over a tick or frame end in the same cycle: no frame_fim is emitted.

Reset
REQ-022 SHALL, with rst=1 at an edge, set state=OCIOSO, row=0, prescaler=0, buffer=0, linha=0, coluna=0 and frame_fim=0.
REQ-023 SHALL give rst priority over en and all other events, including mid-frame.
REQ-024 SHALL, after rst is released with en=1, follow REQ-018 from the first edge with rst=0.

Configuration
REQ-025 SHALL support macro VARREDURA_BLANKING_EN.
REQ-026 SHALL, when VARREDURA_BLANKING_EN is defined, insert one APAGA cycle (outputs dark) between consecutive rows: frame period = 7*DIV + 6 + 1 cycles.
REQ-027 SHALL, when VARREDURA_BLANKING_EN is undefined, omit the APAGA state entirely and change rows directly: frame period = 7*DIV + 1 cycles.

Verification
REQ-028 SHALL cover: rst=1 for 3 cycles, en=1 -> linha=0, coluna=0, frame_fim=0 throughout.
REQ-029 SHALL cover: DIV=4, dados[4:0]=5'b10101, dados[9:5]=5'b01110, en raised -> after 2 edges linha=7'b0000001 and coluna=5'b10101 for 4 cycles, then linha=7'b0000010 and coluna=5'b01110 (one dark cycle first if VARREDURA_BLANKING_EN).
REQ-030 SHALL cover: DIV=4, en held at 1 -> frame_fim pulses every 29 cycles (35 with VARREDURA_BLANKING_EN), each pulse 1 cycle wide.
REQ-031 SHALL cover: dados[34:30] changed from 5'b11111 to 5'b00001 while row 2 is shown -> row 6 still shows 5'b11111; the next frame shows 5'b00001.
REQ-032 SHALL cover: en dropped during row 3 -> linha=0 next edge, no frame_fim; en raised again -> row 0 visible 2 edges later.
REQ-033 SHALL cover: rst pulsed for 1 cycle during row 5 with en=1 -> outputs 0 next edge; row 0 visible 2 edges after rst falls.
